scalar_operand_fetch: RTL and testbench

// Operand-fetch (OF) stage between decode and execute of the interpolation ASIP scalar pipe.
// - Drives read addresses into scalar_registers and captures Rout1/Rout2.
// - Resolves RAW hazards: forwards from the MEM and WB stages, and stalls on load-use.
// - Holds the OF/EX pipeline register with a valid/ready handshake and a flush input.

---
 rtl/asip_pkg.sv | 20 ++
 rtl/operand_forward_mux.sv | 37 +++
 rtl/scalar_operand_fetch.sv | 110 +++++++++++
 tb/tb_scalar_operand_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/asip_pkg.sv
// Shared widths, scalar types and the OF/EX pipeline-register payload for the ASIP scalar pipe.
package asip_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [DATA_W-1:0] scalar_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic         valid;
    scalar_data_t op1;
    scalar_data_t op2;
    scalar_data_t imm;
    reg_addr_t    rd;
    logic         reg_write;
    logic         is_load;
  } of_ex_t;

endpackage

// File: rtl/operand_forward_mux.sv
// Priority operand select for one source: MEM result, then WB result, then register-file data.
module operand_forward_mux
  import asip_pkg::*;
(
  input  logic [ADDR_W-1:0] rs,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] operand,
  output logic              match
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data yet; the hazard logic stalls on it instead.
  assign mem_hit = mem_valid & mem_reg_write & ~mem_is_load & (mem_rd == rs);
  assign wb_hit  = wb_valid & wb_reg_write & (wb_rd == rs);
  assign match   = mem_hit | wb_hit;

  always_comb begin
    operand = rf_data;
    if (mem_hit) begin
      operand = mem_data;
    end else if (wb_hit) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/scalar_operand_fetch.sv
// Operand-fetch stage: register reads, MEM/WB forwarding, load-use stall and the OF/EX register.
module scalar_operand_fetch
  import asip_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [DATA_W-1:0] id_imm,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_rout1,
  input  logic [DATA_W-1:0] rf_rout2,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              of_valid,
  output logic [DATA_W-1:0] of_op1,
  output logic [DATA_W-1:0] of_op2,
  output logic [DATA_W-1:0] of_imm,
  output logic [ADDR_W-1:0] of_rd,
  output logic              of_reg_write,
  output logic              of_is_load
);

  of_ex_t       of_q;
  scalar_data_t op1;
  scalar_data_t op2;
  logic         fwd1;
  logic         fwd2;
  logic         of_load_hz;
  logic         mem_load_hz;
  logic         hz;
  logic         advance;
  logic         take;

  assign rf_rs1 = id_rs1;
  assign rf_rs2 = id_rs2;

  operand_forward_mux u_fwd1 (
    .rs(id_rs1), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .rf_data(rf_rout1), .operand(op1), .match(fwd1)
  );

  operand_forward_mux u_fwd2 (
    .rs(id_rs2), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .rf_data(rf_rout2), .operand(op2), .match(fwd2)
  );

  // Load results exist only at WB, so a load in OF or MEM feeding either source stalls decode.
  assign of_load_hz  = of_q.valid & of_q.is_load & of_q.reg_write &
                       ((of_q.rd == id_rs1) | (of_q.rd == id_rs2));
  assign mem_load_hz = mem_valid & mem_is_load & mem_reg_write &
                       ((mem_rd == id_rs1) | (mem_rd == id_rs2));
  assign hz          = of_load_hz | mem_load_hz;

  assign advance  = ~of_q.valid | ex_ready;
  assign id_ready = advance & ~hz & ~flush;
  assign take     = id_valid & ~hz;

  always_ff @(posedge clk) begin
    if (rst) begin
      of_q <= '0;
    end else if (flush) begin
      of_q.valid <= 1'b0;
    end else if (advance) begin
      of_q.valid <= take;
      if (take) begin
        of_q.op1       <= op1;
        of_q.op2       <= op2;
        of_q.imm       <= id_imm;
        of_q.rd        <= id_rd;
        of_q.reg_write <= id_reg_write;
        of_q.is_load   <= id_is_load;
      end
    end
  end

  assign of_valid     = of_q.valid;
  assign of_op1       = of_q.op1;
  assign of_op2       = of_q.op2;
  assign of_imm       = of_q.imm;
  assign of_rd        = of_q.rd;
  assign of_reg_write = of_q.reg_write;
  assign of_is_load   = of_q.is_load;

  // Forward-hit flags are kept for debug visibility; they do not alter the datapath.
  logic fwd_any;
  assign fwd_any = fwd1 | fwd2;
  logic unused_fwd;
  assign unused_fwd = fwd_any & 1'b0;

endmodule

// File: tb/tb_scalar_operand_fetch.sv
// Directed self-checking bench for scalar_operand_fetch with a behavioural register-file model.
module tb_scalar_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, id_is_load;
  logic [31:0] id_imm;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rout1, rf_rout2;
  logic        mem_valid, mem_reg_write, mem_is_load;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_ready;
  logic        of_valid;
  logic [31:0] of_op1, of_op2, of_imm;
  logic [4:0]  of_rd;
  logic        of_reg_write, of_is_load;

  logic [31:0] regs [32];
  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign rf_rout1 = regs[rf_rs1];
  assign rf_rout2 = regs[rf_rs2];

  scalar_operand_fetch dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_imm(id_imm), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rout1(rf_rout1), .rf_rout2(rf_rout2), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
    .mem_data(mem_data), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
    .of_valid(of_valid), .of_op1(of_op1), .of_op2(of_op2), .of_imm(of_imm),
    .of_rd(of_rd), .of_reg_write(of_reg_write), .of_is_load(of_is_load)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic [31:0] imm);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_is_load = ld; id_imm = imm;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    regs[0] = 32'd7; regs[3] = 32'd100; regs[5] = 32'd50;
    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_reg_write = 1'b0; id_is_load = 1'b0; id_imm = '0;
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_is_load = 1'b0; mem_rd = '0; mem_data = '0;
    wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(of_valid), 32'd0);
    chk("rst_op1", of_op1, 32'd0);
    chk("rst_op2", of_op2, 32'd0);
    chk("rst_imm", of_imm, 32'd0);
    chk("rst_rd", 32'(of_rd), 32'd0);
    chk("rst_rw", 32'(of_reg_write), 32'd0);
    chk("rst_ld", 32'(of_is_load), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(id_ready), 32'd1);

    // Plain register-file read
    offer(5'd3, 5'd0, 5'd1, 1'b1, 1'b0, 32'd5);
    #1;
    chk("rf_addr1", 32'(rf_rs1), 32'd3);
    chk("plain_ready", 32'(id_ready), 32'd1);
    tick();
    chk("plain_valid", 32'(of_valid), 32'd1);
    chk("plain_op1", of_op1, 32'd100);
    chk("plain_op2", of_op2, 32'd7);
    chk("plain_imm", of_imm, 32'd5);
    chk("plain_rd", 32'(of_rd), 32'd1);

    // MEM beats WB, then WB alone
    offer(5'd0, 5'd2, 5'd6, 1'b1, 1'b0, 32'd0);
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd2; mem_data = 32'd55;
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd2; wb_data = 32'd9;
    tick();
    chk("fwd_mem_op2", of_op2, 32'd55);
    chk("fwd_mem_op1", of_op1, 32'd7);
    mem_valid = 1'b0;
    tick();
    chk("fwd_wb_op2", of_op2, 32'd9);
    wb_valid = 1'b0;

    // Load-use: load in OF, then in MEM, then data from WB
    offer(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 32'd0);
    tick();
    chk("load_in_of", 32'(of_is_load), 32'd1);
    offer(5'd4, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0);
    #1;
    chk("lu_ready_c0", 32'(id_ready), 32'd0);
    tick();
    chk("lu_bubble1", 32'(of_valid), 32'd0);
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd4; mem_data = 32'hDEAD;
    #1;
    chk("lu_ready_c1", 32'(id_ready), 32'd0);
    tick();
    chk("lu_bubble2", 32'(of_valid), 32'd0);
    mem_valid = 1'b0; mem_is_load = 1'b0;
    wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd4; wb_data = 32'd77;
    #1;
    chk("lu_ready_c2", 32'(id_ready), 32'd1);
    tick();
    chk("lu_issue_valid", 32'(of_valid), 32'd1);
    chk("lu_issue_op1", of_op1, 32'd77);
    chk("lu_issue_rd", 32'(of_rd), 32'd7);
    wb_valid = 1'b0;

    // Execute back-pressure
    ex_ready = 1'b0;
    offer(5'd5, 5'd3, 5'd8, 1'b1, 1'b0, 32'h11);
    #1;
    chk("stall_ready", 32'(id_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_valid", 32'(of_valid), 32'd1);
      chk("stall_op1", of_op1, 32'd77);
      chk("stall_rd", 32'(of_rd), 32'd7);
    end
    ex_ready = 1'b1;
    #1;
    chk("unstall_ready", 32'(id_ready), 32'd1);
    tick();
    chk("unstall_op1", of_op1, 32'd50);
    chk("unstall_op2", of_op2, 32'd100);
    chk("unstall_imm", of_imm, 32'h11);
    chk("unstall_rd", 32'(of_rd), 32'd8);

    // Flush drops the offered instruction
    offer(5'd3, 5'd3, 5'd9, 1'b1, 1'b0, 32'd0);
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(id_ready), 32'd0);
    tick();
    chk("flush_valid", 32'(of_valid), 32'd0);
    flush = 1'b0;

    // Reset during a stall
    offer(5'd3, 5'd0, 5'd10, 1'b1, 1'b0, 32'd0);
    tick();
    chk("pre_stall_rd", 32'(of_rd), 32'd10);
    ex_ready = 1'b0;
    offer(5'd5, 5'd5, 5'd11, 1'b1, 1'b0, 32'd0);
    tick();
    chk("held_rd", 32'(of_rd), 32'd10);
    rst = 1'b1;
    tick();
    chk("rst_stall_valid", 32'(of_valid), 32'd0);
    chk("rst_stall_rd", 32'(of_rd), 32'd0);
    chk("rst_stall_op1", of_op1, 32'd0);
    rst = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(id_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
